// File: rtl/sync_filter_many.sv
// ----------------------------------------------------------------------------
// sync_filter_many
//
// Bank of WIDTH independent single-bit synchronisers. Each one brings an
// asynchronous level input into the clk domain, then applies a persistence
// (glitch) filter, registered edge pulses and a sticky event flag. Channels
// are independent. The bank does not keep multi-bit values coherent, so do not
// use it to cross a bus.
//
// Parameters
//   WIDTH        number of channels (1..64)
//   SYNC_FF      synchroniser flop stages per channel (2..8)
//   FILT_CYCLES  consecutive cycles a new synced level must persist before
//                outs follows it (1..65535, 1 = no filtering)
//   INIT_VAL     reset value of the sync chain and of outs
//
// Ports
//   clk         single clock, all logic lives here
//   rst         synchronous active-high reset
//   ins         asynchronous level inputs
//   clr_sticky  per-channel synchronous clear of sticky
//   outs        filtered, synchronised levels
//   rise        one-cycle pulse: outs[i] went 0->1 this cycle
//   fall        one-cycle pulse: outs[i] went 1->0 this cycle
//   sticky      set on any outs[i] change, held until cleared
// ----------------------------------------------------------------------------
module sync_filter_many #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       SYNC_FF     = 2,
  parameter int unsigned       FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0]  INIT_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ins,
  input  logic [WIDTH-1:0] clr_sticky,
  output logic [WIDTH-1:0] outs,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] sticky
);

  // The counter reaches FILT_CYCLES-1 at most. It keeps one bit even when
  // FILT_CYCLES is 1, where the filter degenerates into a single extra register.
  localparam int unsigned      CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  // Synchroniser stages. No logic sits between them, so placement tools can
  // pack the chain tightly.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_FF];
  logic [WIDTH-1:0] sync_s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] outs_q,   outs_d;
  logic [WIDTH-1:0] rise_q,   rise_d;
  logic [WIDTH-1:0] fall_q,   fall_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] update;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_FF; k++) begin
        sync_q[k] <= INIT_VAL;
      end
    end else begin
      sync_q[0] <= ins;
      for (int k = 1; k < SYNC_FF; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_FF-1];

  // Persistence filter. A channel's counter measures how long the synced
  // level has disagreed with outs. Any return to agreement restarts the count,
  // so a glitch shorter than FILT_CYCLES leaves no trace.
  always_comb begin
    outs_d = outs_q;
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != outs_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          outs_d[i] = sync_s[i];
          update[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pulses are registered together with outs, so they line up with the
  // cycle in which the new level first appears. When a clear and an update
  // arrive together, the update wins, so no event is ever lost.
  assign rise_d   = update & sync_s;
  assign fall_d   = update & ~sync_s;
  assign sticky_d = (sticky_q & ~clr_sticky) | update;

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q   <= INIT_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      outs_q   <= outs_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign outs   = outs_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign sticky = sticky_q;

  // A channel can never rise and fall in the same cycle.
  riseFallExclusive : assert property (@(posedge clk) disable iff (rst)
    (rise_q & fall_q) == '0);

  // Every change of outs comes with exactly one pulse, and every pulse comes
  // with a change of outs.
  pulseMatchesChange : assert property (@(posedge clk) disable iff (rst)
    (rise_d | fall_d) == (outs_d ^ outs_q));

endmodule

// File: tb/tb_sync_filter_many.sv
// ----------------------------------------------------------------------------
// tb_sync_filter_many
//
// Self-checking bench for sync_filter_many. It uses two instances:
//   dutA  WIDTH=4, SYNC_FF=2, FILT_CYCLES=4, INIT_VAL=0
//   dutB  WIDTH=4, SYNC_FF=3, FILT_CYCLES=1, INIT_VAL=4'hA
// A behavioural model of each instance is stepped on every rising edge. A
// scoreboard compares both instances against their models on the falling
// edge. A table of directed cycles and a few hand-written sequences check
// hand-derived values on top of that.
// ----------------------------------------------------------------------------
module tb_sync_filter_many;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, rstB;
  logic [3:0] insA, clrA, outsA, riseA, fallA, stickyA;
  logic [3:0] insB, clrB, outsB, riseB, fallB, stickyB;

  sync_filter_many #(.WIDTH(4), .SYNC_FF(2), .FILT_CYCLES(4), .INIT_VAL(4'h0)) dutA (
    .clk(clk), .rst(rstA), .ins(insA), .clr_sticky(clrA),
    .outs(outsA), .rise(riseA), .fall(fallA), .sticky(stickyA)
  );

  sync_filter_many #(.WIDTH(4), .SYNC_FF(3), .FILT_CYCLES(1), .INIT_VAL(4'hA)) dutB (
    .clk(clk), .rst(rstB), .ins(insB), .clr_sticky(clrB),
    .outs(outsB), .rise(riseB), .fall(fallB), .sticky(stickyB)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chkEn       = 1'b0;

  // Model state. hist[0] holds the most recent input sample. The synced level
  // is the sample taken syncFf-1 edges earlier. run counts how many
  // consecutive edges that level has disagreed with outs.
  typedef struct packed {
    logic [7:0][3:0]  hist;
    logic [3:0]       outs;
    logic [3:0]       rise;
    logic [3:0]       fall;
    logic [3:0]       sticky;
    logic [3:0][15:0] run;
  } model_t;

  model_t mA, mB;

  function automatic model_t modelStep(model_t m, logic rst, logic [3:0] ins,
                                       logic [3:0] clr, int syncFf, int filt,
                                       logic [3:0] init);
    model_t     n;
    logic [3:0] s;
    logic [3:0] upd;
    n = m;
    if (rst) begin
      for (int j = 0; j < 8; j++) n.hist[j] = init;
      n.outs   = init;
      n.rise   = '0;
      n.fall   = '0;
      n.sticky = '0;
      n.run    = '0;
      return n;
    end
    s   = m.hist[syncFf-1];
    upd = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] != m.outs[i]) begin
        if (m.run[i] + 16'd1 >= 16'(filt)) begin
          n.outs[i] = s[i];
          upd[i]    = 1'b1;
          n.run[i]  = '0;
        end else begin
          n.run[i] = m.run[i] + 16'd1;
        end
      end else begin
        n.run[i] = '0;
      end
    end
    n.rise   = upd & s;
    n.fall   = upd & ~s;
    n.sticky = (m.sticky & ~clr) | upd;
    for (int j = 7; j > 0; j--) n.hist[j] = m.hist[j-1];
    n.hist[0] = ins;
    return n;
  endfunction

  always @(posedge clk) begin
    mA = modelStep(mA, rstA, insA, clrA, 2, 4, 4'h0);
    mB = modelStep(mB, rstB, insB, clrB, 3, 1, 4'hA);
  end

  task automatic checkOutput(string name, logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("modelA.outs",   outsA,   mA.outs);
      checkOutput("modelA.rise",   riseA,   mA.rise);
      checkOutput("modelA.fall",   fallA,   mA.fall);
      checkOutput("modelA.sticky", stickyA, mA.sticky);
      checkOutput("modelB.outs",   outsB,   mB.outs);
      checkOutput("modelB.rise",   riseB,   mB.rise);
      checkOutput("modelB.fall",   fallB,   mB.fall);
      checkOutput("modelB.sticky", stickyB, mB.sticky);
    end
  end

  // Directed cycles for dutA. Each entry holds the inputs for one edge and
  // the outputs expected after that edge.
  typedef struct {
    logic       rst;
    logic [3:0] ins;
    logic [3:0] clr;
    logic [3:0] outs;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] sticky;
  } vec_t;

  vec_t tbl[$];

  task automatic addRows(int n, logic rst, logic [3:0] ins, logic [3:0] clr,
                         logic [3:0] outs, logic [3:0] rise, logic [3:0] fall,
                         logic [3:0] sticky);
    for (int k = 0; k < n; k++) tbl.push_back('{rst, ins, clr, outs, rise, fall, sticky});
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    rstA = v.rst;
    insA = v.ins;
    clrA = v.clr;
    cycle();
    checkOutput($sformatf("row%0d.outs", idx),   outsA,   v.outs);
    checkOutput($sformatf("row%0d.rise", idx),   riseA,   v.rise);
    checkOutput($sformatf("row%0d.fall", idx),   fallA,   v.fall);
    checkOutput($sformatf("row%0d.sticky", idx), stickyA, v.sticky);
  endtask

  logic [3:0] seq [12];
  logic [3:0] expOuts, expPrev;

  initial begin
    rstA = 1'b1; insA = 4'h0; clrA = 4'h0;
    rstB = 1'b1; insB = 4'hA; clrB = 4'h0;
    repeat (2) @(negedge clk);
    chkEn = 1'b1;

    // Reset held with all inputs high, then a full-latency step after release.
    addRows(3, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(5, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF);
    addRows(2, 0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
    addRows(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Three-cycle glitch on ch0 is filtered; a four-cycle hold is not.
    addRows(3, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(5, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1);
    addRows(1, 0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
    addRows(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Rise then fall on ch1.
    addRows(5, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2);
    addRows(1, 0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
    addRows(5, 0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
    addRows(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
    addRows(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    addRows(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Clear on the update cycle loses nothing; a clear on its own clears.
    addRows(5, 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4);
    addRows(1, 0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    addRows(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Reset at filter count 2 on ch3, then the full latency again.
    addRows(4, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(5, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    addRows(1, 0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h8);

    foreach (tbl[k]) applyStimulus(tbl[k], k);

    // dutB: no filter and three sync stages, so outs follows ins four edges later.
    rstB = 1'b1; insB = 4'hA;
    repeat (2) cycle();
    checkOutput("B.resetOuts",   outsB,   4'hA);
    checkOutput("B.resetSticky", stickyB, 4'h0);
    rstB = 1'b0;
    repeat (3) cycle();
    checkOutput("B.idleOuts",   outsB,         4'hA);
    checkOutput("B.idlePulses", riseB | fallB, 4'h0);
    for (int r = 0; r < 12; r++) seq[r] = ((r / 2) % 2 == 0) ? 4'h5 : 4'hA;
    for (int r = 0; r < 12; r++) begin
      insB = seq[r];
      cycle();
      if (r < 3) begin
        expOuts = 4'hA;
        expPrev = 4'hA;
      end else begin
        expOuts = seq[r-3];
        expPrev = (r >= 4) ? seq[r-4] : 4'hA;
      end
      checkOutput($sformatf("B.toggle%0d.outs", r),   outsB,   expOuts);
      checkOutput($sformatf("B.toggle%0d.rise", r),   riseB,   expOuts & ~expPrev);
      checkOutput($sformatf("B.toggle%0d.fall", r),   fallB,   ~expOuts & expPrev);
      checkOutput($sformatf("B.toggle%0d.sticky", r), stickyB, (r >= 3) ? 4'hF : 4'h0);
    end

    // Random phase. Input bits flip rarely enough that some changes survive
    // the filter. The scoreboard checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) insA[i] = ~insA[i];
        if ($urandom_range(0, 3) == 0) insB[i] = ~insB[i];
        clrA[i] = ($urandom_range(0, 7) == 0);
        clrB[i] = ($urandom_range(0, 7) == 0);
      end
      rstA = ($urandom_range(0, 99) == 0);
      rstB = ($urandom_range(0, 99) == 0);
      cycle();
    end

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
